// File: rtl/rv32i_types.sv
// Shared RV32I core types: pipeline stage indices and reset fetch address.
package rv32i_types;

  // Stage indices of the default 5-stage in-order pipeline.
  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  localparam int NUM_STAGES_DEFAULT     = 5;
  localparam int REDIRECT_STAGE_DEFAULT = STAGE_EX;

  // First fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

  // Width of the architectural instruction step.
  localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating 32-bit event counter with increment enable.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_d, cnt_q;

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: fetch PC, per-stage valid bits, per-stage
// load/bubble enables and retire order counter for the in-order RV32I core.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import rv32i_types::*;
#(
  parameter int                  NUM_STAGES     = NUM_STAGES_DEFAULT,
  parameter int                  REDIRECT_STAGE = REDIRECT_STAGE_DEFAULT,
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = PC_WIDTH'(RESET_PC_DEFAULT),
  parameter int                  ORDER_WIDTH    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_STAGES-1:0]  stall_req,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [NUM_STAGES-1:0]  stage_valid,
  output logic [NUM_STAGES-1:0]  load_en,
  output logic [NUM_STAGES-1:0]  bubble,
  output logic                   retire,
  output logic [ORDER_WIDTH-1:0] order,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_flushes
);

  localparam logic [NUM_STAGES-1:0] VALID_RST = NUM_STAGES'(1);

  logic [NUM_STAGES-1:0]  frozen;
  logic [NUM_STAGES-1:0]  bubble_raw;
  logic                   redirect_taken;

  logic [PC_WIDTH-1:0]    pc_d, pc_q;
  logic [NUM_STAGES-1:0]  stage_valid_d, stage_valid_q;
  logic [ORDER_WIDTH-1:0] order_d, order_q;

  // Target low bits are dropped: fetch is always word aligned.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // A stall holds its own stage and everything upstream of it.
  genvar gi;
  for (gi = 0; gi < NUM_STAGES; gi++) begin : g_frz
    assign frozen[gi] = |stall_req[NUM_STAGES-1:gi];
  end

  // A redirect from a frozen stage waits until that stage can advance.
  assign redirect_taken = rst & redirect_valid & ~frozen[REDIRECT_STAGE];

  // Bubble where the upstream stage is frozen, or where a redirect squashes
  // the wrong-path instructions at or above the redirecting stage.
  assign bubble_raw[0] = 1'b0;
  for (gi = 1; gi < NUM_STAGES; gi++) begin : g_bub
    if (gi <= REDIRECT_STAGE) begin : g_flush
      assign bubble_raw[gi] = ~frozen[gi] & (frozen[gi-1] | redirect_taken);
    end else begin : g_noflush
      assign bubble_raw[gi] = ~frozen[gi] & frozen[gi-1];
    end
  end

  // Everything is quiet while reset is held.
  assign load_en = rst ? ~frozen   : '0;
  assign bubble  = rst ? bubble_raw : '0;
  assign retire  = rst & stage_valid_q[NUM_STAGES-1] & ~stall_req[NUM_STAGES-1];

  // Valid bits: hold when frozen, clear on bubble, otherwise shift down.
  always_comb begin
    stage_valid_d    = stage_valid_q;
    stage_valid_d[0] = 1'b1;
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (!frozen[i]) begin
        stage_valid_d[i] = bubble_raw[i] ? 1'b0 : stage_valid_q[i-1];
      end
    end
  end

  // Next fetch address: redirect wins over sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect_taken) begin
      pc_d = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    end else if (!frozen[0]) begin
      pc_d = pc_q + PC_WIDTH'(INSN_BYTES);
    end
  end

  // Retire order counts prior retirements and wraps naturally.
  always_comb begin
    order_d = order_q;
    if (retire) order_d = order_q + ORDER_WIDTH'(1);
  end

  // Sequencing state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      stage_valid_q <= VALID_RST;
      order_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      stage_valid_q <= stage_valid_d;
      order_q       <= order_d;
    end
  end

  assign pc          = pc_q;
  assign stage_valid = stage_valid_q;
  assign order       = order_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (|stall_req),
    .cnt (perf_stall_cycles)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_taken),
    .cnt (perf_flushes)
  );
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for the default pipe plus
// hand sequences for async reset and order wrap.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst, rst2;
  logic [4:0]  stall_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [4:0]  stage_valid, load_en, bubble;
  logic        retire;
  logic [63:0] order;
  logic [31:0] perf_stall_cycles, perf_flushes;

  logic [4:0]  stall2;
  logic        rv2;
  logic [31:0] rpc2;
  logic [31:0] pc2;
  logic [4:0]  valid2, ld2, bub2;
  logic        ret2;
  logic [3:0]  ord2;
  logic [31:0] pst2, pfl2;

  int errors = 0;
  int checks = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .pc(pc), .stage_valid(stage_valid), .load_en(load_en),
    .bubble(bubble), .retire(retire), .order(order),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
  );

  pipe_ctrl #(.ORDER_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst2), .stall_req(stall2), .redirect_valid(rv2),
    .redirect_pc(rpc2), .pc(pc2), .stage_valid(valid2), .load_en(ld2),
    .bubble(bub2), .retire(ret2), .order(ord2),
    .perf_stall_cycles(pst2), .perf_flushes(pfl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  stall;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [4:0]  vld;
    logic [4:0]  ld;
    logic [4:0]  bub;
    logic        ret;
    logic [63:0] ord;
    logic [31:0] pst;
    logic [31:0] pfl;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(input logic [4:0] st, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] p, input logic [4:0] v, input logic [4:0] l,
                              input logic [4:0] b, input logic r, input int o,
                              input int ps, input int pf);
    vec_t t;
    t.stall = st; t.rv = rv; t.rpc = rpc; t.pc = p; t.vld = v; t.ld = l;
    t.bub = b; t.ret = r; t.ord = 64'(o); t.pst = 32'(ps); t.pfl = 32'(pf);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pst, exp_pfl;

    //           stall     rv  rpc           pc            vld       ld        bub      ret ord pst pfl
    tv[0]  = mk(5'b00000, 0, 32'h0,        32'h1eceb000, 5'b00001, 5'b11111, 5'b00000, 0, 0, 0, 0);
    tv[1]  = mk(5'b00000, 0, 32'h0,        32'h1eceb004, 5'b00011, 5'b11111, 5'b00000, 0, 0, 0, 0);
    tv[2]  = mk(5'b00000, 0, 32'h0,        32'h1eceb008, 5'b00111, 5'b11111, 5'b00000, 0, 0, 0, 0);
    tv[3]  = mk(5'b00000, 0, 32'h0,        32'h1eceb00c, 5'b01111, 5'b11111, 5'b00000, 0, 0, 0, 0);
    tv[4]  = mk(5'b00000, 0, 32'h0,        32'h1eceb010, 5'b11111, 5'b11111, 5'b00000, 1, 0, 0, 0);
    tv[5]  = mk(5'b00000, 0, 32'h0,        32'h1eceb014, 5'b11111, 5'b11111, 5'b00000, 1, 1, 0, 0);
    tv[6]  = mk(5'b01000, 0, 32'h0,        32'h1eceb018, 5'b11111, 5'b10000, 5'b10000, 1, 2, 0, 0);
    tv[7]  = mk(5'b01000, 0, 32'h0,        32'h1eceb018, 5'b01111, 5'b10000, 5'b10000, 0, 3, 1, 0);
    tv[8]  = mk(5'b01000, 0, 32'h0,        32'h1eceb018, 5'b01111, 5'b10000, 5'b10000, 0, 3, 2, 0);
    tv[9]  = mk(5'b00000, 0, 32'h0,        32'h1eceb018, 5'b01111, 5'b11111, 5'b00000, 0, 3, 3, 0);
    tv[10] = mk(5'b00000, 0, 32'h0,        32'h1eceb01c, 5'b11111, 5'b11111, 5'b00000, 1, 3, 3, 0);
    tv[11] = mk(5'b00000, 1, 32'h1eceb103, 32'h1eceb020, 5'b11111, 5'b11111, 5'b00110, 1, 4, 3, 0);
    tv[12] = mk(5'b00000, 0, 32'h0,        32'h1eceb100, 5'b11001, 5'b11111, 5'b00000, 1, 5, 3, 1);
    tv[13] = mk(5'b00000, 0, 32'h0,        32'h1eceb104, 5'b10011, 5'b11111, 5'b00000, 1, 6, 3, 1);
    tv[14] = mk(5'b00000, 0, 32'h0,        32'h1eceb108, 5'b00111, 5'b11111, 5'b00000, 0, 7, 3, 1);
    tv[15] = mk(5'b01000, 1, 32'h1eceb200, 32'h1eceb10c, 5'b01111, 5'b10000, 5'b10000, 0, 7, 3, 1);
    tv[16] = mk(5'b01000, 1, 32'h1eceb200, 32'h1eceb10c, 5'b01111, 5'b10000, 5'b10000, 0, 7, 4, 1);
    tv[17] = mk(5'b00000, 1, 32'h1eceb200, 32'h1eceb10c, 5'b01111, 5'b11111, 5'b00110, 0, 7, 5, 1);
    tv[18] = mk(5'b00000, 0, 32'h0,        32'h1eceb200, 5'b11001, 5'b11111, 5'b00000, 1, 7, 5, 2);
    tv[19] = mk(5'b00001, 1, 32'h1eceb300, 32'h1eceb204, 5'b10011, 5'b11110, 5'b00110, 1, 8, 5, 2);
    tv[20] = mk(5'b00000, 0, 32'h0,        32'h1eceb300, 5'b00001, 5'b11111, 5'b00000, 0, 9, 6, 3);
    tv[21] = mk(5'b10000, 0, 32'h0,        32'h1eceb304, 5'b00011, 5'b00000, 5'b00000, 0, 9, 6, 3);
    tv[22] = mk(5'b00000, 0, 32'h0,        32'h1eceb304, 5'b00011, 5'b11111, 5'b00000, 0, 9, 7, 3);
    tv[23] = mk(5'b00010, 0, 32'h0,        32'h1eceb308, 5'b00111, 5'b11100, 5'b00100, 0, 9, 7, 3);
    tv[24] = mk(5'b00000, 0, 32'h0,        32'h1eceb308, 5'b01011, 5'b11111, 5'b00000, 0, 9, 8, 3);

    // Reset held with a redirect pending: controls must stay quiet.
    rst = 1'b0; rst2 = 1'b0;
    stall_req = '0; redirect_valid = 1'b1; redirect_pc = 32'h1eceb400;
    stall2 = '0; rv2 = 1'b0; rpc2 = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.pc",      64'(pc),          64'h1eceb000);
    chk("rst.valid",   64'(stage_valid), 64'h1);
    chk("rst.load_en", 64'(load_en),     64'h0);
    chk("rst.bubble",  64'(bubble),      64'h0);
    chk("rst.retire",  64'(retire),      64'h0);
    chk("rst.order",   order,            64'h0);
    chk("rst.pst",     64'(perf_stall_cycles), 64'h0);
    chk("rst.pfl",     64'(perf_flushes),      64'h0);

    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      stall_req      = tv[i].stall;
      redirect_valid = tv[i].rv;
      redirect_pc    = tv[i].rpc;
      #1;
`ifdef PIPE_CTRL_PERF_EN
      exp_pst = tv[i].pst;
      exp_pfl = tv[i].pfl;
`else
      exp_pst = 32'h0;
      exp_pfl = 32'h0;
`endif
      chk($sformatf("v%0d.pc", i),      64'(pc),          64'(tv[i].pc));
      chk($sformatf("v%0d.valid", i),   64'(stage_valid), 64'(tv[i].vld));
      chk($sformatf("v%0d.load_en", i), 64'(load_en),     64'(tv[i].ld));
      chk($sformatf("v%0d.bubble", i),  64'(bubble),      64'(tv[i].bub));
      chk($sformatf("v%0d.retire", i),  64'(retire),      64'(tv[i].ret));
      chk($sformatf("v%0d.order", i),   order,            tv[i].ord);
      chk($sformatf("v%0d.pst", i),     64'(perf_stall_cycles), 64'(exp_pst));
      chk($sformatf("v%0d.pfl", i),     64'(perf_flushes),      64'(exp_pfl));
      @(negedge clk);
    end
    stall_req = '0; redirect_valid = 1'b0;

    // Mid-cycle reset clears state without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    chk("arst.pc",      64'(pc),          64'h1eceb000);
    chk("arst.valid",   64'(stage_valid), 64'h1);
    chk("arst.order",   order,            64'h0);
    chk("arst.load_en", 64'(load_en),     64'h0);
    chk("arst.retire",  64'(retire),      64'h0);
    chk("arst.pfl",     64'(perf_flushes), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst.first_pc", 64'(pc), 64'h1eceb000);
    @(posedge clk);
    #1;
    chk("arst.next_pc",  64'(pc), 64'h1eceb004);
    chk("arst.valid2",   64'(stage_valid), 64'h3);

    // Narrow order counter: 17 back-to-back retires wrap 15 -> 0.
    @(negedge clk);
    rst2 = 1'b1;
    for (int k = 0; k < 21; k++) begin
      #1;
      if (k < 4) begin
        chk($sformatf("wrap%0d.retire", k), 64'(ret2), 64'h0);
      end else begin
        chk($sformatf("wrap%0d.retire", k), 64'(ret2), 64'h1);
        chk($sformatf("wrap%0d.order", k),  64'(ord2), 64'((k - 4) % 16));
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
